csr_unit: RTL

- Parametrised machine-mode CSR unit for the Klaw core. It replaces the flat write-only CSR register bank.
- Adds combinational read with atomic RW/RS/RC operations, and WARL/read-only enforcement with illegal-access flagging.
- Adds trap entry and mret state updates, trap-vector computation and interrupt-pending generation.
- Sits beside the execute stage; the exception/commit logic drives the trap and mret inputs.

---
 rtl/csr_pkg.sv | 50 +++++
 rtl/csr_counter64.sv | 36 +++
 rtl/csr_unit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the Klaw machine-mode CSR unit: CSR addresses,
// operation encoding, mstatus/mip bit positions and interrupt cause codes.
package csr_pkg;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_t;

  // mstatus fields
  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  // mip / mie bit positions
  localparam int unsigned MIP_MSIP = 3;
  localparam int unsigned MIP_MTIP = 7;
  localparam int unsigned MIP_MEIP = 11;

  // misa extension bit for the base integer ISA
  localparam int unsigned MISA_I_BIT = 8;

  // Interrupt cause codes (mcause low bits when MSB is set)
  localparam int unsigned IRQ_CAUSE_SW    = 3;
  localparam int unsigned IRQ_CAUSE_TIMER = 7;
  localparam int unsigned IRQ_CAUSE_EXT   = 11;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with an increment enable and independent
// low/high word write ports. Any write in a cycle suppresses that cycle's
// increment so the written value is what reads back next cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_lo_i,
  input  logic [31:0] wdata_hi_i,
  output logic [63:0] cnt_o
);

  logic [63:0] cnt_q, cnt_d;

  // Next count: writes take precedence over the increment
  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) cnt_d[31:0]  = wdata_lo_i;
      if (wr_hi_i) cnt_d[63:32] = wdata_hi_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit for the Klaw core: combinational read, atomic
// RW/RS/RC writes with WARL and read-only enforcement, trap entry / mret
// state updates, trap-vector computation and interrupt-pending generation.
// Optional mcycle/minstret counters are built when KLAW_CSR_COUNTERS_EN is
// defined; otherwise their addresses decode as unimplemented.
//
// Handshake: csr_v_i is a single-cycle valid with no ready; an access is
// always accepted in the cycle it is presented, its read data and illegal
// flag are valid in that same cycle, and its write lands on the next edge.
module csr_unit
  import csr_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] MHARTID     = '0,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            csr_v_i,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_adr_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic            trap_v_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_tval_i,
  input  logic            mret_v_i,
  input  logic            instret_i,
  input  logic            irq_sw_i,
  input  logic            irq_timer_i,
  input  logic            irq_ext_i,
  output logic [XLEN-1:0] trap_target_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            irq_pending_o
);

  localparam logic [XLEN-1:0] ALIGN4 = {{(XLEN-2){1'b1}}, 2'b00};
  // mtvec MODE values 2/3 are reserved and collapse to direct mode
  localparam logic [XLEN-1:0] MTVEC_RST_WARL =
    {MTVEC_RESET[XLEN-1:2], MTVEC_RESET[1] ? 2'b00 : MTVEC_RESET[1:0]};

  logic            status_mie_q, status_mie_d;
  logic            status_mpie_q, status_mpie_d;
  logic [2:0]      mie_en_q, mie_en_d;   // {MEIE, MTIE, MSIE}
  logic [2:0]      mip_q;                // {MEIP, MTIP, MSIP}
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;

  logic [XLEN-1:0] rdata;
  logic            impl;
  logic [XLEN-1:0] wval;
  logic            we;
  logic [XLEN-1:0] mtvec_base;

`ifdef KLAW_CSR_COUNTERS_EN
  logic [63:0] mcycle_cnt, minstret_cnt;
  logic [63:0] wval64;
  logic        cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;
  logic [31:0] wdata_hi;
`else
  logic        unused_instret;
  assign unused_instret = instret_i;
`endif

  // Read mux and implemented-address decode
  always_comb begin
    rdata = '0;
    impl  = 1'b1;
    case (csr_adr_i)
      CSR_MSTATUS: begin
        rdata[MSTATUS_MIE]                   = status_mie_q;
        rdata[MSTATUS_MPIE]                  = status_mpie_q;
        rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      CSR_MISA: begin
        rdata[XLEN-1:XLEN-2] = (XLEN == 64) ? 2'd2 : 2'd1;
        rdata[MISA_I_BIT]    = 1'b1;
      end
      CSR_MIE: begin
        rdata[MIP_MSIP] = mie_en_q[0];
        rdata[MIP_MTIP] = mie_en_q[1];
        rdata[MIP_MEIP] = mie_en_q[2];
      end
      CSR_MIP: begin
        rdata[MIP_MSIP] = mip_q[0];
        rdata[MIP_MTIP] = mip_q[1];
        rdata[MIP_MEIP] = mip_q[2];
      end
      CSR_MTVEC:     rdata = mtvec_q;
      CSR_MSCRATCH:  rdata = mscratch_q;
      CSR_MEPC:      rdata = mepc_q;
      CSR_MCAUSE:    rdata = mcause_q;
      CSR_MTVAL:     rdata = mtval_q;
      CSR_MVENDORID: rdata = '0;
      CSR_MARCHID:   rdata = '0;
      CSR_MIMPID:    rdata = '0;
      CSR_MHARTID:   rdata = MHARTID;
`ifdef KLAW_CSR_COUNTERS_EN
      CSR_MCYCLE:    rdata = XLEN'(mcycle_cnt);
      CSR_MINSTRET:  rdata = XLEN'(minstret_cnt);
      CSR_MCYCLEH: begin
        if (XLEN == 32) rdata = XLEN'(mcycle_cnt >> 32);
        else            impl  = 1'b0;
      end
      CSR_MINSTRETH: begin
        if (XLEN == 32) rdata = XLEN'(minstret_cnt >> 32);
        else            impl  = 1'b0;
      end
`endif
      default: impl = 1'b0;
    endcase
  end

  assign csr_rdata_o   = rdata;
  assign csr_illegal_o = csr_v_i &
                         (~impl | ((csr_op_i != CSR_OP_NONE) & (csr_adr_i[11:10] == 2'b11)));

  // Atomic read-modify-write value
  always_comb begin
    case (csr_op_t'(csr_op_i))
      CSR_OP_RW: wval = csr_wdata_i;
      CSR_OP_RS: wval = rdata | csr_wdata_i;
      CSR_OP_RC: wval = rdata & ~csr_wdata_i;
      default:   wval = rdata;
    endcase
  end

  // A trap in the same cycle drops the CSR write entirely
  assign we = csr_v_i & ~csr_illegal_o & ~trap_v_i & (csr_op_i != CSR_OP_NONE);

  // Next state: trap entry beats mret, mret beats a CSR write to mstatus
  always_comb begin
    status_mie_d  = status_mie_q;
    status_mpie_d = status_mpie_q;
    mie_en_d      = mie_en_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    if (trap_v_i) begin
      mepc_d        = trap_pc_i & ALIGN4;
      mcause_d      = trap_cause_i;
      mtval_d       = trap_tval_i;
      status_mpie_d = status_mie_q;
      status_mie_d  = 1'b0;
    end else begin
      if (we) begin
        case (csr_adr_i)
          CSR_MSTATUS: begin
            status_mie_d  = wval[MSTATUS_MIE];
            status_mpie_d = wval[MSTATUS_MPIE];
          end
          CSR_MIE:      mie_en_d   = {wval[MIP_MEIP], wval[MIP_MTIP], wval[MIP_MSIP]};
          CSR_MTVEC:    mtvec_d    = {wval[XLEN-1:2], wval[1] ? 2'b00 : wval[1:0]};
          CSR_MSCRATCH: mscratch_d = wval;
          CSR_MEPC:     mepc_d     = wval & ALIGN4;
          CSR_MCAUSE:   mcause_d   = wval;
          CSR_MTVAL:    mtval_d    = wval;
          default: ;
        endcase
      end
      if (mret_v_i) begin
        status_mie_d  = status_mpie_q;
        status_mpie_d = 1'b1;
      end
    end
  end

  // CSR state registers and interrupt-line sampling
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_mie_q  <= 1'b0;
      status_mpie_q <= 1'b0;
      mie_en_q      <= '0;
      mip_q         <= '0;
      mtvec_q       <= MTVEC_RST_WARL;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
    end else begin
      status_mie_q  <= status_mie_d;
      status_mpie_q <= status_mpie_d;
      mie_en_q      <= mie_en_d;
      mip_q         <= {irq_ext_i, irq_timer_i, irq_sw_i};
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
    end
  end

  // Vectored mode only offsets for interrupts; exceptions go to BASE
  assign mtvec_base    = mtvec_q & ALIGN4;
  assign trap_target_o = ((mtvec_q[1:0] == 2'b01) && trap_cause_i[XLEN-1])
                         ? mtvec_base + (XLEN'(trap_cause_i[XLEN-2:0]) << 2)
                         : mtvec_base;
  assign mepc_o        = mepc_q;
  assign irq_pending_o = status_mie_q & |(mip_q & mie_en_q);

`ifdef KLAW_CSR_COUNTERS_EN
  // On XLEN=64 the low address covers the full counter
  assign wval64    = 64'(wval);
  assign wdata_hi  = (XLEN == 64) ? wval64[63:32] : wval64[31:0];
  assign cyc_wr_lo = we & (csr_adr_i == CSR_MCYCLE);
  assign cyc_wr_hi = we & ((csr_adr_i == CSR_MCYCLEH) | ((XLEN == 64) & (csr_adr_i == CSR_MCYCLE)));
  assign ins_wr_lo = we & (csr_adr_i == CSR_MINSTRET);
  assign ins_wr_hi = we & ((csr_adr_i == CSR_MINSTRETH) | ((XLEN == 64) & (csr_adr_i == CSR_MINSTRET)));

  csr_counter64 u_mcycle (
    .clk        (clk),
    .reset_n    (reset_n),
    .inc_i      (1'b1),
    .wr_lo_i    (cyc_wr_lo),
    .wr_hi_i    (cyc_wr_hi),
    .wdata_lo_i (wval64[31:0]),
    .wdata_hi_i (wdata_hi),
    .cnt_o      (mcycle_cnt)
  );

  csr_counter64 u_minstret (
    .clk        (clk),
    .reset_n    (reset_n),
    .inc_i      (instret_i),
    .wr_lo_i    (ins_wr_lo),
    .wr_hi_i    (ins_wr_hi),
    .wdata_lo_i (wval64[31:0]),
    .wdata_hi_i (wdata_hi),
    .cnt_o      (minstret_cnt)
  );
`endif

endmodule
